ped_phase_controller: RTL and testbench

- Sequential traffic-phase master that produces the 5-bit pedestrian phase count and the light-out flag consumed by the pedestrian-signal downcounter/display path.
- Drives the car and pedestrian lamp outputs.
- Sequences car green, yellow, all-red, pedestrian walk/clear and night flash.
- All timing advances on a 1 Hz enable tick from the system prescaler.

---
 rtl/ped_pkg.sv | 31 +++
 rtl/ped_phase_timer.sv | 36 +++
 rtl/ped_phase_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_ped_phase_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian phase controller.
//   - ped_state_t : phase FSM state encoding
//   - CAR_*       : car lamp encodings {red, yellow, green}
//   - PED_*       : pedestrian lamp encodings {red, green}
//   - CNT_IDLE    : count_out value while no pedestrian phase is running
//   - CLEAR_START : count_out value at which the walk phase becomes clearance
package ped_pkg;

    typedef enum logic [2:0] {
        CAR_GREEN,
        CAR_YELLOW,
        ALLRED1,
        PED_WALK,
        PED_CLEAR,
        ALLRED2,
        NIGHT_FLASH
    } ped_state_t;

    localparam logic [2:0] CAR_R   = 3'b100;
    localparam logic [2:0] CAR_Y   = 3'b010;
    localparam logic [2:0] CAR_G   = 3'b001;
    localparam logic [2:0] CAR_OFF = 3'b000;

    localparam logic [1:0] PED_R   = 2'b10;
    localparam logic [1:0] PED_G   = 2'b01;
    localparam logic [1:0] PED_OFF = 2'b00;

    localparam logic [4:0] CNT_IDLE    = 5'd31;
    localparam logic [4:0] CLEAR_START = 5'd3;

endpackage

// File: rtl/ped_phase_timer.sv
// ped_phase_timer: loadable, tick-enabled down counter with terminal flag.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (value <= RST_VAL)
//   tick         : enable; nothing changes without it
//   load/load_val: load value on tick (takes priority over dec)
//   dec          : decrement on tick
//   value        : registered counter value
//   last         : value == 1 (final tick of an N-tick phase)
module ped_phase_timer #(
    parameter int unsigned    W       = 5,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= RST_VAL;
        end else if (tick) begin
            if (load)
                value <= load_val;
            else if (dec)
                value <= value - W'(1);
        end
    end

    assign last = (value == W'(1));

endmodule

// File: rtl/ped_phase_controller.sv
// ped_phase_controller: traffic phase master driving car/pedestrian lamps and
// the 5-bit pedestrian count consumed by the downcounter/display path.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   tick           : 1 Hz one-clk enable; all phase timing advances on it
//   ped_req        : debounced pedestrian button (level or pulse)
//   night_mode     : request for flashing-yellow night operation
//   count_out      : pedestrian count, 31 when no pedestrian phase active
//   light_out_time : high during night flash (display blanks)
//   car_light      : {red, yellow, green}
//   ped_light      : {red, green}
//   ped_wait       : pedestrian request pending
// Build option: define PED_BLINK_EN to blink ped green during clearance;
// otherwise ped green is solid during clearance.
module ped_phase_controller #(
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned MAX_GREEN = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_LOAD  = 26,
    parameter int unsigned TMR_W     = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [4:0] count_out,
    output logic       light_out_time,
    output logic [2:0] car_light,
    output logic [1:0] ped_light,
    output logic       ped_wait
);

    import ped_pkg::*;

    localparam logic [TMR_W-1:0] MIN_G     = TMR_W'(MIN_GREEN);
    localparam logic [TMR_W-1:0] MAX_G     = TMR_W'(MAX_GREEN);
    localparam logic [TMR_W-1:0] YEL       = TMR_W'(YELLOW_T);
    localparam logic [TMR_W-1:0] AR        = TMR_W'(ALLRED_T);
    localparam logic [4:0]       PED_START = 5'(PED_LOAD);

    ped_state_t       state, nxt;
    logic [TMR_W-1:0] tmr, tmr_val, grn_inc;
    logic             tmr_load, tmr_dec, tmr_last;
    logic [4:0]       cnt_val;
    logic             cnt_load, cnt_dec, cnt_last;
    logic             flash, flash_nxt;
`ifdef PED_BLINK_EN
    logic             ped_blink, blink_nxt;
`endif

    // Phase timer; in CAR_GREEN it is reloaded with an incremented value so
    // the same down counter also serves as the saturating green up-count.
    ped_phase_timer #(.W(TMR_W), .RST_VAL('0)) u_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .value    (tmr),
        .last     (tmr_last)
    );

    // Pedestrian count; its register is count_out itself.
    ped_phase_timer #(.W(5), .RST_VAL(CNT_IDLE)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .value    (count_out),
        .last     (cnt_last)
    );

    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = tmr;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = CNT_IDLE;
        // Decision uses the post-tick green time so green lasts MAX_GREEN ticks.
        grn_inc  = (tmr >= MAX_G) ? MAX_G : tmr + TMR_W'(1);
        case (state)
            CAR_GREEN: begin
                if (night_mode) begin
                    nxt = NIGHT_FLASH;
                end else if (grn_inc == MAX_G || (grn_inc >= MIN_G && ped_wait)) begin
                    nxt      = CAR_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = YEL;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = grn_inc;
                end
            end
            CAR_YELLOW: begin
                if (night_mode) begin
                    nxt = NIGHT_FLASH;
                end else if (tmr_last) begin
                    nxt      = ALLRED1;
                    tmr_load = 1'b1;
                    tmr_val  = AR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ALLRED1: begin
                if (night_mode) begin
                    nxt = NIGHT_FLASH;
                end else if (tmr_last) begin
                    nxt      = PED_WALK;
                    cnt_load = 1'b1;
                    cnt_val  = PED_START;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PED_WALK: begin
                cnt_dec = 1'b1;
                if (count_out == CLEAR_START + 5'd1)
                    nxt = PED_CLEAR;
            end
            PED_CLEAR: begin
                if (count_out == '0) begin
                    nxt      = ALLRED2;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_IDLE;
                    tmr_load = 1'b1;
                    tmr_val  = AR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ALLRED2: begin
                // Night request is honoured only after the full all-red, so a
                // pedestrian phase is always followed by ALLRED_T red ticks.
                if (tmr_last) begin
                    if (night_mode) begin
                        nxt = NIGHT_FLASH;
                    end else begin
                        nxt      = CAR_GREEN;
                        tmr_load = 1'b1;
                        tmr_val  = '0;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            NIGHT_FLASH: begin
                if (!night_mode) begin
                    nxt      = ALLRED2;
                    tmr_load = 1'b1;
                    tmr_val  = AR;
                end
            end
            default: nxt = CAR_GREEN;
        endcase

        flash_nxt = (nxt == NIGHT_FLASH) ? ((state == NIGHT_FLASH) ? ~flash : 1'b1) : 1'b0;
`ifdef PED_BLINK_EN
        blink_nxt = (nxt == PED_CLEAR && state == PED_CLEAR) ? ~ped_blink : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= CAR_GREEN;
            car_light      <= CAR_G;
            ped_light      <= PED_R;
            light_out_time <= 1'b0;
            flash          <= 1'b0;
            ped_wait       <= 1'b0;
`ifdef PED_BLINK_EN
            ped_blink      <= 1'b0;
`endif
        end else begin
            // Request latch runs every clk, independent of tick.
            if (tick && state == ALLRED1 && nxt == PED_WALK)
                ped_wait <= 1'b0;
            else if (ped_req && (state == CAR_GREEN || state == CAR_YELLOW ||
                                 state == NIGHT_FLASH))
                ped_wait <= 1'b1;

            if (tick) begin
                state          <= nxt;
                flash          <= flash_nxt;
                light_out_time <= (nxt == NIGHT_FLASH);
`ifdef PED_BLINK_EN
                ped_blink      <= blink_nxt;
`endif
                case (nxt)
                    CAR_GREEN:  begin car_light <= CAR_G; ped_light <= PED_R; end
                    CAR_YELLOW: begin car_light <= CAR_Y; ped_light <= PED_R; end
                    ALLRED1,
                    ALLRED2:    begin car_light <= CAR_R; ped_light <= PED_R; end
                    PED_WALK:   begin car_light <= CAR_R; ped_light <= PED_G; end
                    PED_CLEAR: begin
                        car_light <= CAR_R;
`ifdef PED_BLINK_EN
                        ped_light <= blink_nxt ? PED_G : PED_OFF;
`else
                        ped_light <= PED_G;
`endif
                    end
                    NIGHT_FLASH: begin
                        car_light <= flash_nxt ? CAR_Y : CAR_OFF;
                        ped_light <= PED_OFF;
                    end
                    default:    begin car_light <= CAR_G; ped_light <= PED_R; end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_phase_controller.sv
// Directed self-checking bench for ped_phase_controller (default parameters).
module tb_ped_phase_controller;

    localparam logic [2:0] C_R   = 3'b100;
    localparam logic [2:0] C_Y   = 3'b010;
    localparam logic [2:0] C_G   = 3'b001;
    localparam logic [2:0] C_OFF = 3'b000;
    localparam logic [1:0] P_R   = 2'b10;
    localparam logic [1:0] P_G   = 2'b01;
    localparam logic [1:0] P_OFF = 2'b00;

    logic       clk = 1'b0;
    logic       reset_n, tick, ped_req, night_mode;
    logic [4:0] count_out;
    logic       light_out_time;
    logic [2:0] car_light;
    logic [1:0] ped_light;
    logic       ped_wait;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ped_phase_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick           (tick),
        .ped_req        (ped_req),
        .night_mode     (night_mode),
        .count_out      (count_out),
        .light_out_time (light_out_time),
        .car_light      (car_light),
        .ped_light      (ped_light),
        .ped_wait       (ped_wait)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // One-clk tick; returns on the following negedge with outputs settled.
    task automatic pulse();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Called right after the tick that entered CAR_YELLOW.
    task automatic to_walk_from_yellow(input string tag);
        pulse(); check({tag, "_y2"}, car_light, C_Y);
        pulse(); check({tag, "_y3"}, car_light, C_Y);
        pulse(); check({tag, "_ar1a"}, car_light, C_R); check({tag, "_ar1a_p"}, ped_light, P_R);
        pulse(); check({tag, "_ar1b"}, car_light, C_R); check({tag, "_ar1b_cnt"}, count_out, 31);
        pulse(); check({tag, "_walk_car"}, car_light, C_R);
        check({tag, "_walk_ped"}, ped_light, P_G);
        check({tag, "_walk_cnt"}, count_out, 26);
        check({tag, "_walk_wait"}, ped_wait, 0);
    endtask

    // Called right after the tick that entered PED_WALK at count 26.
    task automatic run_ped_phase(input int night_at, input bit hold_req);
        logic [1:0] pexp;
        if (hold_req) ped_req = 1'b1;
        for (int c = 25; c >= 0; c--) begin
            pulse();
            if (c >= 4) pexp = P_G;
            else begin
`ifdef PED_BLINK_EN
                pexp = (((3 - c) % 2) == 1) ? P_G : P_OFF;
`else
                pexp = P_G;
`endif
            end
            check("ped_cnt", count_out, c);
            check("ped_lamp", ped_light, pexp);
            check("ped_car", car_light, C_R);
            if (c == night_at) night_mode = 1'b1;
            if (hold_req && c == 15) check("hold_wait", ped_wait, 0);
            if (c == 3) ped_req = 1'b0;
        end
        pulse();
        check("ar2_cnt", count_out, 31);
        check("ar2_ped", ped_light, P_R);
        check("ar2_car", car_light, C_R);
        check("ar2_lo", light_out_time, 0);
        pulse();
        check("ar2b_car", car_light, C_R);
        pulse();
        if (night_mode) begin
            check("nf_car", car_light, C_Y);
            check("nf_lo", light_out_time, 1);
            check("nf_ped", ped_light, P_OFF);
            check("nf_cnt", count_out, 31);
        end else begin
            check("grn_car", car_light, C_G);
            check("grn_ped", ped_light, P_R);
        end
        if (hold_req) check("hold_wait_end", ped_wait, 0);
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt", count_out, 31);
        check("rst_lo", light_out_time, 0);
        check("rst_car", car_light, C_G);
        check("rst_ped", ped_light, P_R);
        check("rst_wait", ped_wait, 0);
        reset_n = 1'b1;

        // No request: 30 green ticks, 3 yellow, 2 all-red, then walk.
        for (int t = 1; t <= 30; t++) begin
            pulse();
            check("t1_car", car_light, (t < 30) ? C_G : C_Y);
            check("t1_cnt", count_out, 31);
        end
        to_walk_from_yellow("t1");
        run_ped_phase(-1, 1'b0);

        // Request after green tick 2, served after tick 10; night at count 15.
        pulse(); pulse();
        check("t2_wait0", ped_wait, 0);
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        check("t2_wait1", ped_wait, 1);
        check("t2_car_hold", car_light, C_G);
        for (int t = 3; t <= 10; t++) begin
            pulse();
            check("t2_car", car_light, (t < 10) ? C_G : C_Y);
        end
        to_walk_from_yellow("t2");
        run_ped_phase(15, 1'b0);
        pulse(); check("nf2_car", car_light, C_OFF); check("nf2_lo", light_out_time, 1);
        pulse(); check("nf3_car", car_light, C_Y);
        night_mode = 1'b0;
        pulse(); check("nx_car", car_light, C_R); check("nx_lo", light_out_time, 0);
        check("nx_ped", ped_light, P_R);
        pulse(); check("nx2_car", car_light, C_R);
        pulse(); check("nx_grn", car_light, C_G);

        // Request on the same tick that MIN_GREEN is reached: served next tick.
        for (int t = 1; t <= 9; t++) pulse();
        check("t5_car9", car_light, C_G);
        @(negedge clk); ped_req = 1'b1; tick = 1'b1;
        @(negedge clk); ped_req = 1'b0; tick = 1'b0;
        check("t5_car10", car_light, C_G);
        check("t5_wait", ped_wait, 1);
        pulse(); check("t5_car11", car_light, C_Y);
        to_walk_from_yellow("t5");
        run_ped_phase(-1, 1'b1);
        for (int t = 1; t <= 30; t++) begin
            pulse();
            check("t5_full_car", car_light, (t < 30) ? C_G : C_Y);
        end

        // Reset mid-walk at count 12, no tick involved.
        to_walk_from_yellow("t6");
        for (int t = 1; t <= 14; t++) pulse();
        check("t6_cnt12", count_out, 12);
        repeat (3) @(negedge clk);
        check("t6_hold", count_out, 12);
        reset_n = 1'b0;
        #1;
        check("t6_rst_cnt", count_out, 31);
        check("t6_rst_car", car_light, C_G);
        check("t6_rst_ped", ped_light, P_R);
        @(negedge clk); reset_n = 1'b1;

        // Night straight from green; request held through night is served.
        pulse(); pulse(); pulse();
        night_mode = 1'b1;
        pulse(); check("t7_nf_car", car_light, C_Y); check("t7_nf_lo", light_out_time, 1);
        check("t7_nf_ped", ped_light, P_OFF);
        @(negedge clk); ped_req = 1'b1;
        @(negedge clk); ped_req = 1'b0;
        check("t7_wait", ped_wait, 1);
        night_mode = 1'b0;
        pulse(); check("t7_ar_a", car_light, C_R);
        pulse(); check("t7_ar_b", car_light, C_R);
        pulse(); check("t7_grn", car_light, C_G); check("t7_wait_kept", ped_wait, 1);
        for (int t = 1; t <= 10; t++) begin
            pulse();
            check("t7_car", car_light, (t < 10) ? C_G : C_Y);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
